csr_trap_unit: RTL and testbench
================================

Name: csr_trap_unit

Overview:
- Machine-mode CSR file and trap controller for the single-cycle RV32 core.
- Successor to the ecall-only handler. Adds:
  - CSR read/modify/write (csrrw/csrrs/csrrc)
  - multiple synchronous exception causes
  - NUM_IRQ maskable external interrupt lines with synchronisers
  - direct and vectored mtvec
- Sits beside the datapath. The controller supplies decoded trap/CSR strobes. The datapath takes o_trap / o_mret and the redirect PC.

Parameters:
- NUM_IRQ, 4, number of external interrupt lines (1..16), mapped to mip/mie bits 16+k.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.

Ports:
- clk  in  1  clock
- reset_x  in  1  asynchronous, active-low reset
- i_pc  in  32  PC of the instruction in execute
- i_valid  in  1  the execute-stage instruction is real; no trap or CSR write when low
- i_ecall  in  1  decoded ecall
- i_ebreak  in  1  decoded ebreak
- i_illegal  in  1  decoder flagged illegal instruction
- i_mret  in  1  decoded mret
- i_csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC
- i_csr_addr  in  12  CSR address
- i_csr_wdata  in  32  rs1 value or zero-extended uimm
- i_irq  in  NUM_IRQ  asynchronous level interrupt requests
- o_csr_rdata  out  32  old CSR value (combinational)
- o_trap  out  1  take trap this cycle (combinational)
- o_mret  out  1  i_valid & i_mret & !o_trap
- o_redirect_pc  out  32  trap target when o_trap; mepc when o_mret; else 0
- o_csr_bad  out  1  CSR access (op≠00) to an unimplemented address, or a write to read-only mip

Behaviour:
- **Reset (async, reset_x low):**
  - mstatus.MIE=0, MPIE=0; mie=0; mtvec=MTVEC_RESET; mscratch=0; mepc=0; mcause=0.
  - Synchronisers cleared.
  - Outputs are combinational from these, so o_trap=0, o_mret=0, o_redirect_pc=0.
- **Implemented CSRs:**
  - mstatus 0x300: MIE bit3, MPIE bit7 writable. MPP[12:11] reads 2'b11. Other bits read 0.
  - mie 0x304: bits 16..16+NUM_IRQ-1 writable, others 0.
  - mtvec 0x305: [31:2] BASE, [1:0] MODE. MODE 2 and 3 are written as 0.
  - mscratch 0x340: full 32 bits.
  - mepc 0x341: bits [1:0] forced 0 on every write.
  - mcause 0x342: full 32 bits writable.
  - mip 0x344: read-only, = synchronised i_irq at bits 16+k.
  - Any other address reads 0, writes are ignored, and o_csr_bad=1.
- **Interrupt sampling:** each i_irq bit passes a 2-flop synchroniser. Latency irq→mip is 2 clk edges.
- **CSR write value:** RW=wdata, RS=old|wdata, RC=old&~wdata. The write commits on the posedge.
  - The write is suppressed when o_trap or !i_valid.
  - RS/RC with wdata=0 still reads and flags, but is not a write for mip purposes.
- **Trap decision** (combinational, i_valid=1), in priority order:
  - Interrupt when MIE & |(mip&mie).
    - Lowest set index k wins.
    - cause = 32'h8000_0000 | (16+k).
  - Otherwise illegal: cause 2.
  - Otherwise ebreak: cause 3.
  - Otherwise ecall: cause 11.
- **On a trap (posedge):**
  - mepc<=i_pc (faulting instruction is not retired).
  - mcause<=cause.
  - MPIE<=MIE, MIE<=0.
- **Trap target:**
  - Exceptions, or MODE=0: {BASE,2'b00}.
  - Interrupt with MODE=1: {BASE,2'b00} + 4*(16+k).
- **On o_mret (posedge):** MIE<=MPIE, MPIE<=1. o_redirect_pc=mepc.
- **Simultaneous events:**
  - Trap beats mret and beats CSR write.
  - A pending interrupt beats a co-issued ecall; mepc is then that ecall's PC.
  - mret with a CSR op in the same cycle: the CSR write is ignored.
- **Reset mid-operation:** all state returns to reset values immediately. Pending synchronised irqs are lost.

Optional Feature:
- Macro: CSR_MCYCLE_EN.
- Defined:
  - 64-bit mcycle counter, +1 every clk, reset 0.
  - Readable and writable at 0xB00 (low) and 0xB80 (high).
  - A written half takes the write value that cycle, with no increment. The other half holds.
- Undefined: 0xB00/0xB80 behave as unimplemented (read 0, o_csr_bad=1).

Test Plan:
- **Ecall trap:** mtvec=0x100, i_pc=0x40, i_ecall=1 → o_trap=1, o_redirect_pc=0x100. Next cycle mepc=0x40, mcause=11, MIE=0.
- **CSR ops:**
  - RW 0x340 with 0xA5A5_0000, then RS with 0x0F → rdata 0xA5A5_0000, mscratch=0xA5A5_000F.
  - RC 0xF0 → mscratch=0xA5A5_000F (RC clears only already-zero bits 7:4).
  - Write mepc 0x123 → reads 0x120.
- **Vectored interrupt:**
  - mtvec=0x201, mie bit17 set, MIE=1.
  - Raise i_irq[1] → o_trap on the 2nd cycle after the edge, target 0x200+4*17=0x244, mcause=0x8000_0011.
- **Priority:** i_illegal & i_ecall together → mcause=2. Pending enabled irq plus ecall → interrupt taken.
- **mret:** after a trap, mret → o_mret=1, o_redirect_pc=mepc, MIE restored to 1, MPIE=1. Masked irq with MIE=0 → no trap.
- **Bad access:** CSR write to 0x344 or 0x7C0 → o_csr_bad=1, state unchanged. Assert reset_x mid-sequence → all CSRs at reset values.

Source files
------------

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and trap controller for the RV32 core.
// Define CSR_MCYCLE_EN to add the 64-bit mcycle/mcycleh counter at 0xB00/0xB80.
module csr_trap_unit #(
    parameter int unsigned NUM_IRQ     = 4,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset_x,
    input  logic [31:0]        i_pc,
    input  logic               i_valid,
    input  logic               i_ecall,
    input  logic               i_ebreak,
    input  logic               i_illegal,
    input  logic               i_mret,
    input  logic [1:0]         i_csr_op,
    input  logic [11:0]        i_csr_addr,
    input  logic [31:0]        i_csr_wdata,
    input  logic [NUM_IRQ-1:0] i_irq,
    output logic [31:0]        o_csr_rdata,
    output logic               o_trap,
    output logic               o_mret,
    output logic [31:0]        o_redirect_pc,
    output logic               o_csr_bad
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    logic               st_mie;
    logic               st_mpie;
    logic [NUM_IRQ-1:0] irq_meta;
    logic [NUM_IRQ-1:0] irq_sync;
    logic [NUM_IRQ-1:0] mie_q;
    logic [29:0]        tvec_base;
    logic               tvec_vec;
    logic [31:0]        mscratch_q;
    logic [31:0]        mepc_q;
    logic [31:0]        mcause_q;

    logic [31:0] mip_word;
    logic [31:0] mie_word;
    logic [31:0] tvec_pc;

    assign mip_word = 32'(irq_sync) << 16;
    assign mie_word = 32'(mie_q) << 16;
    assign tvec_pc  = {tvec_base, 2'b00};

    logic hit_mstatus;
    logic hit_mie;
    logic hit_mtvec;
    logic hit_mscratch;
    logic hit_mepc;
    logic hit_mcause;
    logic hit_mip;

    assign hit_mstatus  = i_csr_addr == A_MSTATUS;
    assign hit_mie      = i_csr_addr == A_MIE;
    assign hit_mtvec    = i_csr_addr == A_MTVEC;
    assign hit_mscratch = i_csr_addr == A_MSCRATCH;
    assign hit_mepc     = i_csr_addr == A_MEPC;
    assign hit_mcause   = i_csr_addr == A_MCAUSE;
    assign hit_mip      = i_csr_addr == A_MIP;

`ifdef CSR_MCYCLE_EN
    localparam logic [11:0] A_MCYCLE  = 12'hB00;
    localparam logic [11:0] A_MCYCLEH = 12'hB80;

    logic        hit_cyc_lo;
    logic        hit_cyc_hi;
    logic [63:0] mcycle_q;

    assign hit_cyc_lo = i_csr_addr == A_MCYCLE;
    assign hit_cyc_hi = i_csr_addr == A_MCYCLEH;
`endif

    logic [31:0] csr_old;
    logic        csr_hit;

    always_comb begin
        csr_old = '0;
        csr_hit = 1'b1;
        unique case (1'b1)
            hit_mstatus:  csr_old = {19'd0, 2'b11, 3'd0, st_mpie,
                                     3'd0, st_mie, 3'd0};
            hit_mie:      csr_old = mie_word;
            hit_mtvec:    csr_old = {tvec_base, 1'b0, tvec_vec};
            hit_mscratch: csr_old = mscratch_q;
            hit_mepc:     csr_old = mepc_q;
            hit_mcause:   csr_old = mcause_q;
            hit_mip:      csr_old = mip_word;
`ifdef CSR_MCYCLE_EN
            hit_cyc_lo:   csr_old = mcycle_q[31:0];
            hit_cyc_hi:   csr_old = mcycle_q[63:32];
`endif
            default:      csr_hit = 1'b0;
        endcase
    end

    logic [31:0] csr_new;

    always_comb begin
        csr_new = i_csr_wdata;
        unique case (i_csr_op)
            OP_RS:   csr_new = csr_old | i_csr_wdata;
            OP_RC:   csr_new = csr_old & ~i_csr_wdata;
            default: csr_new = i_csr_wdata;
        endcase
    end

    // RS/RC with a zero operand is a pure read, so it may touch mip.
    logic mip_write;
    assign mip_write = hit_mip &
                       ((i_csr_op == OP_RW) | (i_csr_wdata != 32'd0));

    assign o_csr_rdata = csr_old;
    assign o_csr_bad   = (i_csr_op != OP_NONE) & (~csr_hit | mip_write);

    logic [NUM_IRQ-1:0] irq_pend;
    logic [3:0]         irq_idx;
    logic               irq_take;
    logic               exc;

    assign irq_pend = irq_sync & mie_q;
    assign irq_take = st_mie & (|irq_pend);
    assign exc      = i_illegal | i_ebreak | i_ecall;

    always_comb begin
        irq_idx = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (irq_pend[i]) irq_idx = i[3:0];
        end
    end

    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] vec_off;

    always_comb begin
        trap_cause = 32'd11;
        if (irq_take)       trap_cause = {1'b1, 26'd0, 1'b1, irq_idx};
        else if (i_illegal) trap_cause = 32'd2;
        else if (i_ebreak)  trap_cause = 32'd3;
    end

    // Vector offset is 4*(16+k); 16+k is just {1,k}.
    assign vec_off = {25'd0, 1'b1, irq_idx, 2'b00};
    assign trap_pc = (irq_take & tvec_vec) ? tvec_pc + vec_off : tvec_pc;

    assign o_trap = i_valid & (irq_take | exc);
    assign o_mret = i_valid & i_mret & ~o_trap;

    always_comb begin
        o_redirect_pc = '0;
        if (o_trap)      o_redirect_pc = trap_pc;
        else if (o_mret) o_redirect_pc = mepc_q;
    end

    logic csr_we;
    assign csr_we = i_valid & (i_csr_op != OP_NONE) & ~o_trap &
                    ~i_mret & ~o_csr_bad;

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            irq_meta <= '0;
            irq_sync <= '0;
        end else begin
            irq_meta <= i_irq;
            irq_sync <= irq_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            st_mie  <= 1'b0;
            st_mpie <= 1'b0;
        end else if (o_trap) begin
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
        end else if (o_mret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (csr_we & hit_mstatus) begin
            st_mie  <= csr_new[3];
            st_mpie <= csr_new[7];
        end
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            mepc_q   <= '0;
            mcause_q <= '0;
        end else if (o_trap) begin
            mepc_q   <= i_pc;
            mcause_q <= trap_cause;
        end else if (csr_we) begin
            if (hit_mepc)   mepc_q   <= {csr_new[31:2], 2'b00};
            if (hit_mcause) mcause_q <= csr_new;
        end
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            mie_q      <= '0;
            tvec_base  <= MTVEC_RESET[31:2];
            tvec_vec   <= MTVEC_RESET[1:0] == 2'b01;
            mscratch_q <= '0;
        end else if (csr_we) begin
            if (hit_mie)      mie_q      <= csr_new[16 +: NUM_IRQ];
            if (hit_mtvec)    tvec_base  <= csr_new[31:2];
            if (hit_mtvec)    tvec_vec   <= csr_new[1:0] == 2'b01;
            if (hit_mscratch) mscratch_q <= csr_new;
        end
    end

`ifdef CSR_MCYCLE_EN
    // A written half takes the new value; that cycle has no increment.
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            mcycle_q <= '0;
        end else if (csr_we & hit_cyc_lo) begin
            mcycle_q[31:0] <= csr_new;
        end else if (csr_we & hit_cyc_hi) begin
            mcycle_q[63:32] <= csr_new;
        end else begin
            mcycle_q <= mcycle_q + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed scenarios with literal expectations, then a
// randomized run compared cycle-by-cycle against a behavioural CSR/trap model.
`timescale 1ns/1ps
module tb_csr_trap_unit;

    localparam int NIRQ = 4;

    logic            clk         = 1'b0;
    logic            reset_x     = 1'b0;
    logic [31:0]     i_pc        = '0;
    logic            i_valid     = 1'b0;
    logic            i_ecall     = 1'b0;
    logic            i_ebreak    = 1'b0;
    logic            i_illegal   = 1'b0;
    logic            i_mret      = 1'b0;
    logic [1:0]      i_csr_op    = '0;
    logic [11:0]     i_csr_addr  = '0;
    logic [31:0]     i_csr_wdata = '0;
    logic [NIRQ-1:0] i_irq       = '0;
    logic [31:0]     o_csr_rdata;
    logic            o_trap;
    logic            o_mret;
    logic [31:0]     o_redirect_pc;
    logic            o_csr_bad;

    always #5 clk = ~clk;

    csr_trap_unit #(
        .NUM_IRQ(NIRQ),
        .MTVEC_RESET(32'h0000_0000)
    ) dut (
        .clk(clk),
        .reset_x(reset_x),
        .i_pc(i_pc),
        .i_valid(i_valid),
        .i_ecall(i_ecall),
        .i_ebreak(i_ebreak),
        .i_illegal(i_illegal),
        .i_mret(i_mret),
        .i_csr_op(i_csr_op),
        .i_csr_addr(i_csr_addr),
        .i_csr_wdata(i_csr_wdata),
        .i_irq(i_irq),
        .o_csr_rdata(o_csr_rdata),
        .o_trap(o_trap),
        .o_mret(o_mret),
        .o_redirect_pc(o_redirect_pc),
        .o_csr_bad(o_csr_bad)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural CSR values as plain words.
    bit              m_mie;
    bit              m_mpie;
    logic [31:0]     m_ie;
    logic [31:0]     m_tvec;
    logic [31:0]     m_scratch;
    logic [31:0]     m_epc;
    logic [31:0]     m_cause;
    logic [NIRQ-1:0] m_hist[$];
`ifdef CSR_MCYCLE_EN
    logic [63:0]     m_cyc;
`endif

    task automatic m_reset();
        m_mie     = 1'b0;
        m_mpie    = 1'b0;
        m_ie      = '0;
        m_tvec    = 32'h0000_0000;
        m_scratch = '0;
        m_epc     = '0;
        m_cause   = '0;
        m_hist.delete();
`ifdef CSR_MCYCLE_EN
        m_cyc     = '0;
`endif
    endtask

    // irq seen at edge n reaches mip after edge n+1.
    function automatic logic [31:0] m_mip();
        if (m_hist.size() >= 2) return 32'(m_hist[m_hist.size() - 2]) << 16;
        return 32'd0;
    endfunction

    function automatic bit m_read(input logic [11:0] a,
                                  output logic [31:0] v);
        v = 32'd0;
        case (a)
            12'h300: v = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h304: v = m_ie;
            12'h305: v = m_tvec;
            12'h340: v = m_scratch;
            12'h341: v = m_epc;
            12'h342: v = m_cause;
            12'h344: v = m_mip();
`ifdef CSR_MCYCLE_EN
            12'hB00: v = m_cyc[31:0];
            12'hB80: v = m_cyc[63:32];
`endif
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic m_eval(output logic [31:0] rd, output bit trap,
                          output bit mret, output logic [31:0] pc,
                          output bit bad, output logic [31:0] cause);
        bit          impl;
        bit          irq;
        int          k;
        logic [31:0] pend;
        impl  = m_read(i_csr_addr, rd);
        pend  = m_mip() & m_ie;
        irq   = m_mie && (pend != 0);
        k     = 0;
        for (int j = 31; j >= 16; j--) if (pend[j]) k = j;
        trap  = i_valid && (irq || i_illegal || i_ebreak || i_ecall);
        cause = irq ? (32'h8000_0000 | 32'(k)) :
                i_illegal ? 32'd2 : i_ebreak ? 32'd3 : 32'd11;
        pc    = 32'd0;
        if (trap) begin
            if (irq && m_tvec[1:0] == 2'b01)
                pc = (m_tvec & ~32'h3) + 32'(4 * k);
            else
                pc = m_tvec & ~32'h3;
        end
        mret = i_valid && i_mret && !trap;
        if (mret) pc = m_epc;
        bad = (i_csr_op != 2'd0) &&
              (!impl || (i_csr_addr == 12'h344 &&
                         (i_csr_op == 2'd1 || i_csr_wdata != 0)));
    endtask

    task automatic m_commit(input logic [31:0] old, input bit trap,
                            input bit mret, input bit bad,
                            input logic [31:0] cause);
        logic [31:0] nv;
        bit          wr;
        if (i_csr_op == 2'd1)      nv = i_csr_wdata;
        else if (i_csr_op == 2'd2) nv = old | i_csr_wdata;
        else                       nv = old & ~i_csr_wdata;
        wr = i_valid && i_csr_op != 2'd0 && !i_mret && !trap && !bad;
`ifdef CSR_MCYCLE_EN
        if (wr && i_csr_addr == 12'hB00)      m_cyc[31:0]  = nv;
        else if (wr && i_csr_addr == 12'hB80) m_cyc[63:32] = nv;
        else                                  m_cyc        = m_cyc + 1;
`endif
        if (trap) begin
            m_epc   = i_pc;
            m_cause = cause;
            m_mpie  = m_mie;
            m_mie   = 1'b0;
        end else if (mret) begin
            m_mie  = m_mpie;
            m_mpie = 1'b1;
        end else if (wr) begin
            case (i_csr_addr)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h304: m_ie      = nv & 32'h000F_0000;
                12'h305: m_tvec    = (nv & ~32'h3) |
                                     (nv[1:0] == 2'b01 ? 32'h1 : 32'h0);
                12'h340: m_scratch = nv;
                12'h341: m_epc     = nv & ~32'h3;
                12'h342: m_cause   = nv;
                default: ;
            endcase
        end
        m_hist.push_back(i_irq);
        if (m_hist.size() > 2) void'(m_hist.pop_front());
    endtask

    // Compare process: inputs change only just after posedge.
    always @(negedge clk) begin
        logic [31:0] e_rd;
        logic [31:0] e_pc;
        logic [31:0] e_cause;
        bit          e_trap;
        bit          e_mret;
        bit          e_bad;
        if (!reset_x) m_reset();
        m_eval(e_rd, e_trap, e_mret, e_pc, e_bad, e_cause);
        chk("m_rdata", o_csr_rdata, e_rd);
        chk("m_trap", 32'(o_trap), 32'(e_trap));
        chk("m_mret", 32'(o_mret), 32'(e_mret));
        chk("m_redirect", o_redirect_pc, e_pc);
        chk("m_bad", 32'(o_csr_bad), 32'(e_bad));
        if (reset_x) m_commit(e_rd, e_trap, e_mret, e_bad, e_cause);
    end

    task automatic setin(input bit v, input bit ec, input bit eb,
                         input bit il, input bit mr, input logic [1:0] op,
                         input logic [11:0] a, input logic [31:0] wd,
                         input logic [31:0] pc);
        i_valid     = v;
        i_ecall     = ec;
        i_ebreak    = eb;
        i_illegal   = il;
        i_mret      = mr;
        i_csr_op    = op;
        i_csr_addr  = a;
        i_csr_wdata = wd;
        i_pc        = pc;
    endtask

    task automatic idle();
        setin(1, 0, 0, 0, 0, 2'd0, 12'h000, 32'd0, 32'd0);
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a,
                       input logic [31:0] wd);
        setin(1, 0, 0, 0, 0, op, a, wd, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    logic [11:0] addrs [10] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                12'h342, 12'h344, 12'h7C0, 12'hB00, 12'hB80};

    initial begin
        m_reset();
        idle();
        repeat (3) @(posedge clk);
        #1;
        reset_x = 1'b1;

        csr(2'd2, 12'h300, 0);
        @(negedge clk);
        chk("rst_mstatus", o_csr_rdata, 32'h1800);
        chk("rst_trap", 32'(o_trap), 0);
        chk("rst_redirect", o_redirect_pc, 0);
        tick();

        csr(2'd1, 12'h305, 32'h100);
        tick();
        setin(1, 1, 0, 0, 0, 2'd0, 12'h0, 0, 32'h40);
        @(negedge clk);
        chk("ecall_trap", 32'(o_trap), 1);
        chk("ecall_target", o_redirect_pc, 32'h100);
        tick();
        csr(2'd2, 12'h341, 0);
        @(negedge clk);
        chk("ecall_mepc", o_csr_rdata, 32'h40);
        tick();
        csr(2'd2, 12'h342, 0);
        @(negedge clk);
        chk("ecall_mcause", o_csr_rdata, 32'd11);
        tick();

        csr(2'd1, 12'h340, 32'hA5A5_0000);
        tick();
        csr(2'd2, 12'h340, 32'h0F);
        @(negedge clk);
        chk("rs_old", o_csr_rdata, 32'hA5A5_0000);
        tick();
        csr(2'd3, 12'h340, 32'hF0);
        @(negedge clk);
        chk("rc_old", o_csr_rdata, 32'hA5A5_000F);
        tick();
        csr(2'd2, 12'h340, 0);
        @(negedge clk);
        chk("rc_result", o_csr_rdata, 32'hA5A5_000F);
        tick();
        csr(2'd1, 12'h341, 32'h123);
        tick();
        csr(2'd2, 12'h341, 0);
        @(negedge clk);
        chk("mepc_align", o_csr_rdata, 32'h120);
        tick();

        csr(2'd1, 12'h305, 32'h201);
        tick();
        csr(2'd1, 12'h304, 32'h1 << 17);
        tick();
        csr(2'd2, 12'h300, 32'h8);
        tick();
        i_irq = 4'b0010;
        @(negedge clk);
        chk("irq_lat0", 32'(o_trap), 0);
        tick();
        @(negedge clk);
        chk("irq_lat1", 32'(o_trap), 0);
        tick();
        setin(1, 1, 0, 0, 0, 2'd0, 12'h0, 0, 32'h80);
        @(negedge clk);
        chk("irq_trap", 32'(o_trap), 1);
        chk("irq_vector", o_redirect_pc, 32'h244);
        tick();
        i_irq = 4'b0000;
        csr(2'd2, 12'h342, 0);
        @(negedge clk);
        chk("irq_mcause", o_csr_rdata, 32'h8000_0011);
        chk("irq_masked", 32'(o_trap), 0);
        tick();
        csr(2'd2, 12'h341, 0);
        @(negedge clk);
        chk("irq_mepc", o_csr_rdata, 32'h80);
        tick();
        csr(2'd2, 12'h300, 0);
        @(negedge clk);
        chk("irq_mstatus", o_csr_rdata, 32'h1880);
        tick();

        setin(1, 0, 0, 0, 1, 2'd1, 12'h340, 0, 0);
        @(negedge clk);
        chk("mret_flag", 32'(o_mret), 1);
        chk("mret_target", o_redirect_pc, 32'h80);
        tick();
        csr(2'd2, 12'h300, 0);
        @(negedge clk);
        chk("mret_mstatus", o_csr_rdata, 32'h1888);
        tick();
        csr(2'd2, 12'h340, 0);
        @(negedge clk);
        chk("mret_nowrite", o_csr_rdata, 32'hA5A5_000F);
        tick();

        setin(1, 1, 0, 1, 0, 2'd0, 12'h0, 0, 32'h50);
        @(negedge clk);
        chk("prio_target", o_redirect_pc, 32'h200);
        tick();
        csr(2'd2, 12'h342, 0);
        @(negedge clk);
        chk("prio_mcause", o_csr_rdata, 32'd2);
        tick();

        csr(2'd1, 12'h344, 32'h5);
        @(negedge clk);
        chk("bad_mip", 32'(o_csr_bad), 1);
        tick();
        csr(2'd1, 12'h7C0, 32'h7);
        @(negedge clk);
        chk("bad_unimpl", 32'(o_csr_bad), 1);
        chk("bad_rdata", o_csr_rdata, 0);
        tick();
        csr(2'd2, 12'h344, 0);
        @(negedge clk);
        chk("mip_read_ok", 32'(o_csr_bad), 0);
        tick();

        csr(2'd1, 12'h340, 32'h1234);
        tick();
        csr(2'd2, 12'h340, 0);
        reset_x = 1'b0;
        @(negedge clk);
        chk("rst_mid_scratch", o_csr_rdata, 0);
        tick();
        reset_x = 1'b1;
        csr(2'd2, 12'h305, 0);
        @(negedge clk);
        chk("rst_mid_mtvec", o_csr_rdata, 0);
        tick();

        for (int c = 0; c < 4000; c++) begin
            logic [31:0] wd;
            case ($urandom_range(0, 3))
                0:       wd = $urandom;
                1:       wd = 32'($urandom_range(0, 255));
                2:       wd = 32'h1 << $urandom_range(16, 19);
                default: wd = 32'd0;
            endcase
            setin($urandom_range(0, 9) != 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 11) == 0,
                  2'($urandom_range(0, 3)),
                  addrs[$urandom_range(0, 9)],
                  wd,
                  $urandom & ~32'h3);
            if ($urandom_range(0, 7) == 0) i_irq = NIRQ'($urandom);
            reset_x = $urandom_range(0, 499) != 0;
            @(posedge clk);
            #1;
        end
        reset_x = 1'b1;
        idle();
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
